// File: rtl/md_seq_pkg.sv
// ----------------------------------------------------------------------------
// md_seq_pkg
// Shared CPU definitions for the multiply/divide unit. The decoder uses the
// same package, so the op encodings exist in one place only.
//   md_op_e      : 3-bit MD operation encoding (MULTU..MTLO)
//   MD_MUL_LAT   : default MULT/MULTU/MADD latency in cycles
//   MD_DIV_LAT   : default DIV/DIVU latency in cycles
//   md_state_e   : sequencer state encoding
// ----------------------------------------------------------------------------
package md_seq_pkg;

    typedef enum logic [2:0] {
        MD_MULTU = 3'b000,
        MD_MULT  = 3'b001,
        MD_DIVU  = 3'b010,
        MD_DIV   = 3'b011,
        MD_MADD  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110
    } md_op_e;

    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a full latency period.
    function automatic logic md_is_arith(input md_op_e op);
        return (op == MD_MULTU) || (op == MD_MULT) || (op == MD_DIVU) ||
               (op == MD_DIV)   || (op == MD_MADD);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_seq_if.sv
// ----------------------------------------------------------------------------
// md_seq_if
// Pipeline-side connection to the multiply/divide sequencer.
//   master : E/D-stage pipeline (drives request, operands, rd_req, flush)
//   slave  : md_seq (returns ready, stall, HI/LO, busy, done)
// ----------------------------------------------------------------------------
interface md_seq_if;
    import md_seq_pkg::*;

    logic        req_valid;
    logic        req_ready;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_req;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output req_valid, op, a, b, rd_req, flush,
        input  req_ready, stall, hi, lo, busy, done
    );

    modport slave (
        input  req_valid, op, a, b, rd_req, flush,
        output req_ready, stall, hi, lo, busy, done
    );

endinterface

// File: rtl/md_arith.sv
// ----------------------------------------------------------------------------
// md_arith
// Purely combinational HI/LO result for every MD op.
//   op        : operation
//   a, b      : operands (rs, rt)
//   hi, lo    : currently committed HI/LO (MADD accumulates onto them)
//   hi_r, lo_r: resulting HI/LO; for MTHI/MTLO the written half carries a
// ----------------------------------------------------------------------------
module md_arith
    import md_seq_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_r,
    output logic [31:0] lo_r
);

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] bu_safe;
    logic [31:0] bs_safe;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Sign-extended 64x64 product truncated to 64 bits is the signed product.
    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Divisors are steered away from 0 (and from the signed overflow pair) so
    // the dividers never produce X; those cases are overridden below anyway.
    assign bu_safe = div_zero ? 32'd1 : b;
    assign bs_safe = (div_zero || div_ovf) ? 32'd1 : b;

    assign quot_u = a / bu_safe;
    assign rem_u  = a % bu_safe;
    // Signed / and % truncate toward zero; remainder takes the dividend sign.
    assign quot_s = $signed(a) / $signed(bs_safe);
    assign rem_s  = $signed(a) % $signed(bs_safe);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        hi_r = hi;
        lo_r = lo;
        case (op)
            MD_MULTU: {hi_r, lo_r} = prod_u;
            MD_MULT:  {hi_r, lo_r} = prod_s;
            MD_MADD:  {hi_r, lo_r} = {hi, lo} + prod_s;
            MD_DIVU: begin
                if (div_zero) begin
                    lo_r = 32'hFFFF_FFFF;
                    hi_r = a;
                end else begin
                    lo_r = quot_u;
                    hi_r = rem_u;
                end
            end
            MD_DIV: begin
                if (div_zero) begin
                    lo_r = 32'hFFFF_FFFF;
                    hi_r = a;
                end else if (div_ovf) begin
                    lo_r = 32'h8000_0000;
                    hi_r = 32'd0;
                end else begin
                    lo_r = quot_s;
                    hi_r = rem_s;
                end
            end
            MD_MTHI: hi_r = a;
            MD_MTLO: lo_r = a;
            default: ;
        endcase
    end

endmodule

// File: rtl/md_seq.sv
// ----------------------------------------------------------------------------
// md_seq
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// The result is computed at acceptance (md_arith) and parked in hi_p/lo_p;
// a down-counter models the functional-unit latency before HI/LO commit.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : md_seq_if.slave (request, operands, rd_req, flush, stall,
//           hi, lo, busy, done)
// Parameters MUL_LAT / DIV_LAT: edges from acceptance to HI/LO commit.
// ----------------------------------------------------------------------------
module md_seq
    import md_seq_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT
) (
    input  logic       clk,
    input  logic       reset,
    md_seq_if.slave    bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [31:0]       hi_q,    hi_d;
    logic [31:0]       lo_q,    lo_d;
    logic [31:0]       hi_p_q,  hi_p_d;
    logic [31:0]       lo_p_q,  lo_p_d;
    logic [31:0]       hi_r;
    logic [31:0]       lo_r;
    logic              req_ready;
    logic              accept;
    logic              done;

    md_arith u_arith (
        .op   (bus.op),
        .a    (bus.a),
        .b    (bus.b),
        .hi   (hi_q),
        .lo   (lo_q),
        .hi_r (hi_r),
        .lo_r (lo_r)
    );

    assign req_ready = (state_q == MD_IDLE) && !bus.flush;
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        done    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    if (bus.op == MD_MTHI) begin
                        hi_d = hi_r;
                    end else if (bus.op == MD_MTLO) begin
                        lo_d = lo_r;
                    end else if (md_is_arith(bus.op)) begin
                        hi_p_d  = hi_r;
                        lo_p_d  = lo_r;
                        cnt_d   = md_is_div(bus.op) ? CNT_W'(DIV_LAT - 1)
                                                    : CNT_W'(MUL_LAT - 1);
                        state_d = MD_RUN;
                    end
                end
            end
            MD_RUN: begin
                // Flush wins over a coinciding final-cycle commit.
                if (bus.flush) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    hi_d    = hi_p_q;
                    lo_d    = lo_p_q;
                    done    = 1'b1;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // NOTE: all architectural state, HI/LO and the pending copies included, is
    // cleared by reset so an interrupted operation can never commit later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_p_q  <= '0;
            lo_p_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.busy      = (state_q == MD_RUN);
    assign bus.done      = done;
    assign bus.stall     = (state_q == MD_RUN) && (bus.rd_req || bus.req_valid);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_md_seq.sv
// ----------------------------------------------------------------------------
// tb_md_seq
// Directed bench for md_seq: expected HI/LO and latency are queued when an
// arithmetic op is issued and compared when the matching done is seen.
// ----------------------------------------------------------------------------
module tb_md_seq;
    import md_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    md_seq_if bus ();

    md_seq #(
        .MUL_LAT (5),
        .DIV_LAT (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; the request is accepted at the next edge.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input bit track, input logic [31:0] eh, input logic [31:0] el,
                         input string tag);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        @(negedge clk);
        check({tag, "_ready"}, bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (track) begin
            e.tag = tag;
            e.hi  = eh;
            e.lo  = el;
            e.lat = (op == MD_DIV || op == MD_DIVU) ? 10 : 5;
            sb.push_back(e);
        end
    endtask

    // Waits (bounded) for done, checks latency/busy/stall, then HI/LO after commit.
    task automatic wait_commit(input bit chk_stall);
        exp_t e;
        int   busy_cycles = 0;
        int   done_at     = 0;
        bit   seen        = 1'b0;
        e = sb.pop_front();
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            if (chk_stall && bus.busy) check({e.tag, "_stall"}, bus.stall, 1);
            if (bus.done) begin
                seen    = 1'b1;
                done_at = i;
            end
        end
        check({e.tag, "_done_seen"}, seen, 1);
        check({e.tag, "_latency"}, done_at, e.lat);
        check({e.tag, "_busy_cycles"}, busy_cycles, e.lat);
        @(posedge clk);
        #1;
        check({e.tag, "_hi"}, bus.hi, e.hi);
        check({e.tag, "_lo"}, bus.lo, e.lo);
        check({e.tag, "_idle_after"}, bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.op        = MD_MULTU;
        bus.a         = '0;
        bus.b         = '0;
        bus.rd_req    = 1'b0;
        bus.flush     = 1'b0;
        #1;
        check("rst_hi",   bus.hi,   0);
        check("rst_lo",   bus.lo,   0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_release_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;

        // MULT -3 * 7
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        wait_commit(1'b0);

        // DIVU then DIV back to back
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, "divu_100_7");
        wait_commit(1'b0);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        wait_commit(1'b0);

        // MTHI / MTLO then MADD carry across LO into HI
        issue(MD_MTHI, 32'd1, 32'd0, 1'b0, '0, '0, "mthi");
        check("mthi_hi", bus.hi, 32'd1);
        check("mthi_busy", bus.busy, 0);
        issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, '0, '0, "mtlo");
        check("mtlo_lo", bus.lo, 32'hFFFF_FFFF);
        check("mtlo_hi", bus.hi, 32'd1);
        @(negedge clk);
        check("mtlo_no_done", bus.done, 0);
        @(posedge clk);
        #1;
        issue(MD_MADD, 32'd1, 32'd1, 1'b1, 32'd2, 32'd0, "madd_carry");
        wait_commit(1'b0);

        // MULTU with rd_req held: stall through every busy cycle
        bus.rd_req = 1'b1;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        wait_commit(1'b1);
        @(negedge clk);
        check("multu_stall_after", bus.stall, 0);
        bus.rd_req = 1'b0;
        @(posedge clk);
        #1;

        // DIV killed by flush on its final cycle
        issue(MD_DIV, 32'd100, 32'd7, 1'b0, '0, '0, "div_flush");
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_final_busy", bus.busy, 1);
        check("flush_final_done", bus.done, 0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_ready_next", bus.req_ready, 1);
        check("flush_busy_next", bus.busy, 0);
        check("flush_hi_kept", bus.hi, 32'hFFFF_FFFE);
        check("flush_lo_kept", bus.lo, 32'h0000_0001);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("flush_no_late_done", dones, 0);
        @(posedge clk);
        #1;

        // Flush in IDLE blocks acceptance
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.op        = MD_MTHI;
        bus.a         = 32'hDEAD_BEEF;
        @(negedge clk);
        check("idle_flush_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        check("idle_flush_hi", bus.hi, 32'hFFFF_FFFE);
        check("idle_flush_busy", bus.busy, 0);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;

        // Division corner cases
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, "div_ovf");
        wait_commit(1'b0);
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, "div_7_m2");
        wait_commit(1'b0);
        issue(MD_DIV, 32'hFFFF_FFF7, 32'd0, 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFF, "div_by0");
        wait_commit(1'b0);

        // Reset asserted between edges during a MULT
        bus.rd_req = 1'b1;
        issue(MD_MULT, 32'd3, 32'd4, 1'b0, '0, '0, "mult_rst");
        @(negedge clk);
        check("mult_rst_busy_pre", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_hi",    bus.hi,    0);
        check("async_rst_lo",    bus.lo,    0);
        check("async_rst_busy",  bus.busy,  0);
        check("async_rst_stall", bus.stall, 0);
        check("async_rst_done",  bus.done,  0);
        @(negedge clk);
        reset      = 1'b0;
        bus.rd_req = 1'b0;
        #1;
        check("rst2_release_ready", bus.req_ready, 1);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("rst2_no_late_done", dones, 0);
        check("rst2_hi_zero", bus.hi, 0);
        @(posedge clk);
        #1;

        issue(MD_DIVU, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, "divu_by0");
        wait_commit(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5, meaning cycles from acceptance to HI/LO commit for MULT/MULTU/MADD.
REQ-002 SHALL have parameter DIV_LAT, default 10, meaning cycles from acceptance to HI/LO commit for DIV/DIVU.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  in  1  E-stage MD instruction present.
REQ-006 SHALL have port req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-007 SHALL have port op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MADD, 101 MTHI, 110 MTLO.
REQ-008 SHALL have ports a and b  in  32  operands (rs, rt); MTHI/MTLO use a only.
REQ-009 SHALL have port rd_req  in  1  D-stage MFHI/MFLO or MD instruction needing HI/LO.
REQ-010 SHALL have port flush  in  1  cancel the in-flight operation (exception/branch kill).
REQ-011 SHALL have port stall  out  1  pipeline freeze request.
REQ-012 SHALL have ports hi and lo  out  32  committed HI/LO values.
REQ-013 SHALL have port busy  out  1  operation in flight.
REQ-014 SHALL have port done  out  1  one-cycle pulse in the cycle HI/LO are committed.

Function
REQ-015 SHALL implement FSM IDLE, RUN, with RUN holding a down-counter cnt and pending registers hi_p/lo_p.
REQ-016 SHALL drive req_ready = (state == IDLE) & ~flush.
REQ-017 SHALL, on accepting MTHI/MTLO, write a into HI/LO at that edge, stay IDLE, and not assert done.
REQ-018 SHALL, on accepting an arithmetic op, capture the result into hi_p/lo_p, load cnt with MUL_LAT-1 or DIV_LAT-1, and enter RUN.
REQ-019 SHALL compute MULTU as the 64-bit unsigned product, MULT as the 64-bit signed product, and MADD as {HI,LO} + signed(a)*signed(b) modulo 2^64, using HI/LO committed at acceptance.
REQ-020 SHALL compute DIV/DIVU as LO = quotient, HI = remainder, with signed truncation toward zero and remainder sign equal to the dividend sign.
REQ-021 SHALL, for b == 0 on DIV/DIVU, commit LO = 32'hFFFF_FFFF and HI = a, never X.
REQ-022 SHALL, for DIV with a = 32'h8000_0000 and b = 32'hFFFF_FFFF, commit LO = 32'h8000_0000 and HI = 0.
REQ-023 SHALL, in RUN, decrement cnt each cycle and, when cnt == 0, commit hi_p/lo_p to HI/LO, pulse done, and return to IDLE at that edge.
REQ-024 SHALL make the total latency exactly MUL_LAT or DIV_LAT rising edges from the acceptance edge to the commit edge, with busy high for exactly that many cycles.
REQ-025 SHALL accept a new request in the cycle immediately after commit, which gives back-to-back throughput of one op per LAT+1 cycles.
REQ-026 SHALL drive stall = busy & (rd_req | req_valid), combinationally.
REQ-027 SHALL, on flush in RUN, return to IDLE at the next edge, discard hi_p/lo_p, leave HI/LO unchanged, and assert no done.
REQ-028 SHALL give flush priority over commit when both fall on the final RUN cycle: nothing is committed.
REQ-029 SHALL, on flush in IDLE with req_valid high, accept nothing and leave HI/LO unchanged.
REQ-030 SHALL update HI/LO only synchronously on clk rising edge, never on any derived edge.

Reset
REQ-031 SHALL, on reset assertion, immediately force state = IDLE, cnt = 0, HI = LO = hi_p = lo_p = 0, and done = busy = stall = 0, regardless of the clock.
REQ-032 SHALL discard any operation in flight during reset, with no commit after release.
REQ-033 SHALL make req_ready high in the first cycle after reset deasserts, given flush is low.

Structure
REQ-034 SHALL take the op encodings (MD_MULTU..MD_MTLO) and the default latencies from the shared CPU definitions package, the same package used by the decoder.
REQ-035 SHALL place the purely combinational result computation (REQ-019..022) in sub-module md_arith (inputs op, a, b, hi, lo; outputs hi_r, lo_r); md_seq holds all state.

Verification
REQ-036 SHALL cover: MULT a=-3 (32'hFFFF_FFFD), b=7 -> done at 5th edge after accept, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB, busy high 5 cycles.
REQ-037 SHALL cover: DIVU a=100, b=7, then DIV a=-7, b=2 -> first commit hi=2, lo=14 after 10 edges; second hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFD; second accepted the cycle after the first done.
REQ-038 SHALL cover: MTHI 1, MTLO 32'hFFFF_FFFF, then MADD a=1, b=1 -> hi=2, lo=0 after 5 edges.
REQ-039 SHALL cover: rd_req held high during MULTU -> stall high every busy cycle and low in the cycle after done.
REQ-040 SHALL cover: DIV started, flush on the 10th cycle -> no done, hi/lo keep prior values, and req_ready is high the next cycle.
REQ-041 SHALL cover: reset asserted mid-MULT between clock edges -> outputs zero immediately and no later done; DIVU b=0, a=5 -> lo=32'hFFFF_FFFF, hi=5.
